borrow_shifting_subtractor: RTL and testbench

- Bit-serial subtractor: computes D = A - B - Bin one bit per clock, LSB first, using a 1-bit full-subtractor cell and shift registers.
- Complements the bit-serial adder in the FPU datapath.
- Used for mantissa subtraction and magnitude comparison (Bout, Z) in effective-subtract paths.
- Start/done handshake with a 3-state FSM; results held stable until the next accepted start.

---
 rtl/borrow_shifting_subtractor.sv | 158 +++++++++++++++
 tb/tb_borrow_shifting_subtractor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/borrow_shifting_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first, with start/done handshake.
// Optional macro SUB_OVERFLOW_EN adds the two's-complement overflow output V.
module borrow_shifting_subtractor #(
    parameter int N = 8
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         Z,
`ifdef SUB_OVERFLOW_EN
    output logic         V,
`endif
    output logic         busy,
    output logic         ready,
    output logic         done
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   s_q, s_d;
    logic           borrow_q, borrow_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   d_q, d_d;
    logic           bout_q, bout_d;
    logic           z_q, z_d;
`ifdef SUB_OVERFLOW_EN
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic           v_q, v_d;
`endif

    logic           diff_s;
    logic           bo_s;
    logic [N-1:0]   s_next_s;

    // Full-subtractor cell on the current LSBs and running borrow
    assign diff_s   = a_q[0] ^ b_q[0] ^ borrow_q;
    assign bo_s     = (~a_q[0] & b_q[0]) | (~a_q[0] & borrow_q) | (b_q[0] & borrow_q);
    assign s_next_s = {diff_s, s_q[N-1:1]};

    // Next-state and datapath update logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        d_d      = d_q;
        bout_d   = bout_q;
        z_d      = z_q;
`ifdef SUB_OVERFLOW_EN
        sa_d     = sa_q;
        sb_d     = sb_q;
        v_d      = v_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    s_d      = '0;
                    count_d  = '0;
`ifdef SUB_OVERFLOW_EN
                    sa_d     = A[N-1];
                    sb_d     = B[N-1];
`endif
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                s_d      = s_next_s;
                a_d      = {1'b0, a_q[N-1:1]};
                b_d      = {1'b0, b_q[N-1:1]};
                borrow_d = bo_s;
                count_d  = count_q + CW'(1);
                // Last bit: publish results; they stay put until the next operation completes
                if (count_q == CW'(N - 1)) begin
                    d_d     = s_next_s;
                    bout_d  = bo_s;
                    z_d     = (s_next_s == '0);
`ifdef SUB_OVERFLOW_EN
                    v_d     = (sa_q ^ sb_q) & (diff_s ^ sa_q);
`endif
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            z_q      <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            v_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            z_q      <= z_d;
`ifdef SUB_OVERFLOW_EN
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            v_q      <= v_d;
`endif
        end
    end

    assign D     = d_q;
    assign Bout  = bout_q;
    assign Z     = z_q;
`ifdef SUB_OVERFLOW_EN
    assign V     = v_q;
`endif
    assign busy  = (state_q == ST_RUN);
    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_borrow_shifting_subtractor.sv
// Self-checking bench for borrow_shifting_subtractor: directed and random operations against an arithmetic model.
module tb_borrow_shifting_subtractor;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic [N-1:0] D;
    logic         Bout;
    logic         Z;
    logic         busy;
    logic         ready;
    logic         done;
`ifdef SUB_OVERFLOW_EN
    logic         V;
    logic         exp_v;
`endif

    int checks;
    int errors;

    logic [N-1:0] exp_d;
    logic         exp_bout;
    logic         exp_z;

    borrow_shifting_subtractor #(.N(N)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .D        (D),
        .Bout     (Bout),
        .Z        (Z),
`ifdef SUB_OVERFLOW_EN
        .V        (V),
`endif
        .busy     (busy),
        .ready    (ready),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsigned (N+1)-bit subtraction: low N bits are D, top bit is the borrow out
    function automatic logic [N:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_held();
        check("d_hold", 32'(D), 32'(exp_d));
        check("bout_hold", 32'(Bout), 32'(exp_bout));
        check("z_hold", 32'(Z), 32'(exp_z));
`ifdef SUB_OVERFLOW_EN
        check("v_hold", 32'(V), 32'(exp_v));
`endif
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check_held();
    endtask

    // Called at a negedge where ready=1; leaves the bench at the negedge of the done cycle
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin, input int glitch_at);
        logic [N:0] r;
        r = ref_sub(a, b, bin);
        A = a;
        B = b;
        Bin = bin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_ready", 32'(ready), 32'd0);
            check("run_done", 32'(done), 32'd0);
            check_held();
            A = N'($urandom);
            B = N'($urandom);
            Bin = 1'($urandom);
            start = (i == glitch_at) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        exp_d = r[N-1:0];
        exp_bout = r[N];
        exp_z = (r[N-1:0] == '0);
`ifdef SUB_OVERFLOW_EN
        exp_v = (a[N-1] ^ b[N-1]) & (r[N-1] ^ a[N-1]);
`endif
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ready", 32'(ready), 32'd1);
        check_held();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
        exp_d = '0;
        exp_bout = 1'b0;
        exp_z = 1'b0;
`ifdef SUB_OVERFLOW_EN
        exp_v = 1'b0;
`endif
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_held();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        run_op(8'h50, 8'h20, 1'b0, -1);
        idle_cycle();
        run_op(8'h20, 8'h50, 1'b0, -1);
        idle_cycle();
        run_op(8'h00, 8'h00, 1'b1, -1);
        idle_cycle();
        run_op(8'h37, 8'h37, 1'b0, -1);
        run_op(8'h01, 8'h00, 1'b0, -1);
        idle_cycle();
        run_op(8'h80, 8'h01, 1'b0, -1);
        idle_cycle();
        run_op(8'h05, 8'h03, 1'b0, -1);
        idle_cycle();
        run_op(8'hA5, 8'h3C, 1'b1, 3);
        idle_cycle();
        idle_cycle();

        for (int k = 0; k < 24; k++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), -1);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end

        // Abort a run with reset after four RUN cycles
        idle_cycle();
        A = 8'hC3;
        B = 8'h11;
        Bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_d = '0;
        exp_bout = 1'b0;
        exp_z = 1'b0;
`ifdef SUB_OVERFLOW_EN
        exp_v = 1'b0;
`endif
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_held();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) idle_cycle();

        run_op(8'h50, 8'h20, 1'b0, -1);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
